// File: rtl/gshare_ras_predictor.sv
// gshare_ras_predictor
//   Fetch-stage next-PC predictor. It is built from four parts:
//     - a tagged direct-mapped BTB,
//     - a gshare PHT of 2-bit saturating counters,
//     - a speculatively updated global history register (GHR),
//     - a return-address stack (RAS).
//   The prediction is combinational from pc_i/instr_i and the current state.
//   The execute stage trains the BTB and PHT. It also repairs GHR and the RAS
//   pointer/count from snapshots that travel with each instruction.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   fetch_valid_i     fetch advances; enables speculative GHR/RAS updates
//   pc_i, instr_i     fetch PC and fetched instruction
//   target_o, taken_o predicted next PC and redirect flag
//   pht_index_o       PHT index used for this fetch (snapshot)
//   ghr_o             GHR before this fetch's update (snapshot)
//   ras_ptr_o         RAS pointer before this fetch (snapshot)
//   ras_count_o       RAS occupancy before this fetch (snapshot)
//   ex_*              resolved branch/jump info, training and repair inputs
module gshare_ras_predictor #(
    parameter int NUM_BTB_ENTRIES = 32,
    parameter int NUM_GHR_BITS    = 3,
    parameter int NUM_PHT_ENTRIES = 1024,
    parameter int RAS_DEPTH       = 8,
    localparam int BTB_IDX_W = $clog2(NUM_BTB_ENTRIES),
    localparam int TAG_W     = 32 - BTB_IDX_W - 2,
    localparam int PHT_IDX_W = $clog2(NUM_PHT_ENTRIES),
    localparam int RAS_PTR_W = $clog2(RAS_DEPTH),
    localparam int RAS_CNT_W = RAS_PTR_W + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_valid_i,
    input  logic [31:0]             pc_i,
    input  logic [31:0]             instr_i,
    output logic [31:0]             target_o,
    output logic                    taken_o,
    output logic [PHT_IDX_W-1:0]    pht_index_o,
    output logic [NUM_GHR_BITS-1:0] ghr_o,
    output logic [RAS_PTR_W-1:0]    ras_ptr_o,
    output logic [RAS_CNT_W-1:0]    ras_count_o,
    input  logic                    ex_branch_i,
    input  logic                    ex_jump_i,
    input  logic                    ex_taken_i,
    input  logic [31:0]             ex_pc_i,
    input  logic [31:0]             ex_target_i,
    input  logic [PHT_IDX_W-1:0]    ex_pht_index_i,
    input  logic [NUM_GHR_BITS-1:0] ex_ghr_i,
    input  logic [RAS_PTR_W-1:0]    ex_ras_ptr_i,
    input  logic [RAS_CNT_W-1:0]    ex_ras_count_i,
    input  logic                    ex_mispredict_i
);

    localparam logic [RAS_CNT_W-1:0] RAS_FULL = RAS_CNT_W'(RAS_DEPTH);

    // Control state (reset)
    logic [NUM_BTB_ENTRIES-1:0]      btbValid;
    logic [NUM_PHT_ENTRIES-1:0][1:0] pht;
    logic [NUM_GHR_BITS-1:0]         ghr;
    logic [RAS_PTR_W-1:0]            rasPtr;
    logic [RAS_CNT_W-1:0]            rasCount;

    // Data state (no reset; qualified by valid bits / RAS count)
    logic [TAG_W-1:0]           btbTag    [NUM_BTB_ENTRIES];
    logic [31:0]                btbTarget [NUM_BTB_ENTRIES];
    logic [NUM_BTB_ENTRIES-1:0] btbIsBranch;
    logic [31:0]                rasStack  [RAS_DEPTH];

    function automatic logic [1:0] satCount(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        res = cnt;
        if (up && cnt != 2'b11) res = cnt + 2'b01;
        if (!up && cnt != 2'b00) res = cnt - 2'b01;
        return res;
    endfunction

    // Written via a wider temporary so that a 1-bit history needs no special case.
    function automatic logic [NUM_GHR_BITS-1:0] shiftGhr(input logic [NUM_GHR_BITS-1:0] hist,
                                                        input logic bit0);
        logic [NUM_GHR_BITS:0] wide;
        wide = {hist, bit0};
        return wide[NUM_GHR_BITS-1:0];
    endfunction

    // Instruction decode
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic       isBranch;
    logic       isJal;
    logic       isJalr;
    logic       isCall;
    logic       isReturn;

    assign opcode   = instr_i[6:0];
    assign rd       = instr_i[11:7];
    assign rs1      = instr_i[19:15];
    assign isBranch = (opcode == 7'b1100011);
    assign isJal    = (opcode == 7'b1101111);
    assign isJalr   = (opcode == 7'b1100111);
    assign isCall   = (isJal || isJalr) && (rd == 5'd1 || rd == 5'd5);
    assign isReturn = isJalr && (rs1 == 5'd1 || rs1 == 5'd5) && (rd == 5'd0);

    // Lookup
    logic [BTB_IDX_W-1:0] fetchBtbIdx;
    logic [TAG_W-1:0]     fetchTag;
    logic                 btbHit;
    logic [PHT_IDX_W-1:0] phtIdx;
    logic [31:0]          pcPlus4;
    logic [RAS_PTR_W-1:0] rasPtrDec;
    logic                 doPop;

    assign fetchBtbIdx = pc_i[BTB_IDX_W+1:2];
    assign fetchTag    = pc_i[31:BTB_IDX_W+2];
    assign btbHit      = btbValid[fetchBtbIdx] && (btbTag[fetchBtbIdx] == fetchTag);
    assign phtIdx      = pc_i[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
    assign pcPlus4     = pc_i + 32'd4;
    assign rasPtrDec   = rasPtr - RAS_PTR_W'(1);
    // An empty stack is never popped; such a return falls through to BTB/PHT.
    assign doPop       = isReturn && (rasCount != '0);

    always_comb begin
        target_o = pcPlus4;
        taken_o  = 1'b0;
        if (doPop) begin
            target_o = rasStack[rasPtrDec];
            taken_o  = 1'b1;
        end else if (btbHit && (!btbIsBranch[fetchBtbIdx] || pht[phtIdx][1])) begin
            target_o = btbTarget[fetchBtbIdx];
            taken_o  = 1'b1;
        end
    end

    assign pht_index_o = phtIdx;
    assign ghr_o       = ghr;
    assign ras_ptr_o   = rasPtr;
    assign ras_count_o = rasCount;

    // Speculative RAS next state: pop first, then push. A combined call+return
    // therefore overwrites the old top in place and leaves the pointer unchanged.
    logic [RAS_PTR_W-1:0] popPtr;
    logic [RAS_CNT_W-1:0] popCount;
    logic [RAS_PTR_W-1:0] rasPtrNext;
    logic [RAS_CNT_W-1:0] rasCountNext;

    always_comb begin
        popPtr       = doPop ? rasPtrDec : rasPtr;
        popCount     = doPop ? (rasCount - RAS_CNT_W'(1)) : rasCount;
        rasPtrNext   = popPtr;
        rasCountNext = popCount;
        if (isCall) begin
            rasPtrNext   = popPtr + RAS_PTR_W'(1);
            // Once full, a push wraps onto the oldest entry and the count stays at depth.
            rasCountNext = (popCount == RAS_FULL) ? popCount : (popCount + RAS_CNT_W'(1));
        end
    end

    logic                 specUpdate;
    logic                 btbWrite;
    logic [BTB_IDX_W-1:0] exBtbIdx;
    logic [TAG_W-1:0]     exTag;

    assign specUpdate = fetch_valid_i && !ex_mispredict_i;
    assign btbWrite   = (ex_branch_i && ex_taken_i) || ex_jump_i;
    assign exBtbIdx   = ex_pc_i[BTB_IDX_W+1:2];
    assign exTag      = ex_pc_i[31:BTB_IDX_W+2];

    always_ff @(posedge clk) begin
        if (reset) begin
            btbValid <= '0;
            pht      <= {NUM_PHT_ENTRIES{2'b01}};
            ghr      <= '0;
            rasPtr   <= '0;
            rasCount <= '0;
        end else begin
            if (ex_branch_i) begin
                pht[ex_pht_index_i] <= satCount(pht[ex_pht_index_i], ex_taken_i);
            end
            if (btbWrite) begin
                btbValid[exBtbIdx] <= 1'b1;
            end
            // Repair wins over the same-cycle wrong-path fetch update.
            if (ex_mispredict_i) begin
                ghr      <= ex_branch_i ? shiftGhr(ex_ghr_i, ex_taken_i) : ex_ghr_i;
                rasPtr   <= ex_ras_ptr_i;
                rasCount <= ex_ras_count_i;
            end else if (fetch_valid_i) begin
                if (isBranch) begin
                    ghr <= shiftGhr(ghr, taken_o);
                end
                rasPtr   <= rasPtrNext;
                rasCount <= rasCountNext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && btbWrite) begin
            btbTag[exBtbIdx]      <= exTag;
            btbTarget[exBtbIdx]   <= ex_target_i;
            btbIsBranch[exBtbIdx] <= ex_branch_i;
        end
        if (!reset && specUpdate && isCall) begin
            rasStack[popPtr] <= pcPlus4;
        end
    end

    // Fields this predictor does not decode.
    logic unusedBits;
    assign unusedBits = ^{instr_i[31:20], instr_i[14:12], pc_i[1:0], ex_pc_i[1:0]};

endmodule

// File: tb/tb_gshare_ras_predictor.sv
module tb_gshare_ras_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic [31:0] target_o;
    logic        taken_o;
    logic [9:0]  pht_index_o;
    logic [2:0]  ghr_o;
    logic [2:0]  ras_ptr_o;
    logic [3:0]  ras_count_o;
    logic        ex_branch_i;
    logic        ex_jump_i;
    logic        ex_taken_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic [9:0]  ex_pht_index_i;
    logic [2:0]  ex_ghr_i;
    logic [2:0]  ex_ras_ptr_i;
    logic [3:0]  ex_ras_count_i;
    logic        ex_mispredict_i;

    gshare_ras_predictor dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_valid_i  (fetch_valid_i),
        .pc_i           (pc_i),
        .instr_i        (instr_i),
        .target_o       (target_o),
        .taken_o        (taken_o),
        .pht_index_o    (pht_index_o),
        .ghr_o          (ghr_o),
        .ras_ptr_o      (ras_ptr_o),
        .ras_count_o    (ras_count_o),
        .ex_branch_i    (ex_branch_i),
        .ex_jump_i      (ex_jump_i),
        .ex_taken_i     (ex_taken_i),
        .ex_pc_i        (ex_pc_i),
        .ex_target_i    (ex_target_i),
        .ex_pht_index_i (ex_pht_index_i),
        .ex_ghr_i       (ex_ghr_i),
        .ex_ras_ptr_i   (ex_ras_ptr_i),
        .ex_ras_count_i (ex_ras_count_i),
        .ex_mispredict_i(ex_mispredict_i)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] BEQ  = 32'h0000_0063; // beq x0,x0,0
    localparam logic [31:0] CALL = 32'h0000_00EF; // jal x1,0
    localparam logic [31:0] RET  = 32'h0000_8067; // jalr x0,0(x1)
    localparam logic [31:0] JMP  = 32'h0000_006F; // jal x0,0

    typedef struct {
        logic        rst;
        logic        chk;
        logic        fv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        exBr;
        logic        exJmp;
        logic        exTk;
        logic        exMp;
        logic [31:0] exPc;
        logic [31:0] exTgt;
        logic [9:0]  exIdx;
        logic [2:0]  exGhr;
        logic [2:0]  exPtr;
        logic [3:0]  exCnt;
        logic        eTaken;
        logic [31:0] eTarget;
        logic [9:0]  eIdx;
        logic [2:0]  eGhr;
        logic [2:0]  ePtr;
        logic [3:0]  eCnt;
    } vec_t;

    vec_t tab[$];
    int checks   = 0;
    int failures = 0;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveFetch(input logic fv, input logic [31:0] pc, input logic [31:0] instr);
        fetch_valid_i = fv;
        pc_i          = pc;
        instr_i       = instr;
    endtask

    task automatic clearEx();
        ex_branch_i     = 1'b0;
        ex_jump_i       = 1'b0;
        ex_taken_i      = 1'b0;
        ex_mispredict_i = 1'b0;
        ex_pc_i         = '0;
        ex_target_i     = '0;
        ex_pht_index_i  = '0;
        ex_ghr_i        = '0;
        ex_ras_ptr_i    = '0;
        ex_ras_count_i  = '0;
    endtask

    task automatic applyVec(input int n);
        vec_t v;
        v = tab[n];
        @(negedge clk);
        reset = v.rst;
        driveFetch(v.fv, v.pc, v.instr);
        ex_branch_i     = v.exBr;
        ex_jump_i       = v.exJmp;
        ex_taken_i      = v.exTk;
        ex_mispredict_i = v.exMp;
        ex_pc_i         = v.exPc;
        ex_target_i     = v.exTgt;
        ex_pht_index_i  = v.exIdx;
        ex_ghr_i        = v.exGhr;
        ex_ras_ptr_i    = v.exPtr;
        ex_ras_count_i  = v.exCnt;
        #1;
        if (v.chk) begin
            checkVal($sformatf("v%0d taken", n), 32'(taken_o), 32'(v.eTaken));
            checkVal($sformatf("v%0d target", n), target_o, v.eTarget);
            checkVal($sformatf("v%0d pht_index", n), 32'(pht_index_o), 32'(v.eIdx));
            checkVal($sformatf("v%0d ghr", n), 32'(ghr_o), 32'(v.eGhr));
            checkVal($sformatf("v%0d ras_ptr", n), 32'(ras_ptr_o), 32'(v.ePtr));
            checkVal($sformatf("v%0d ras_count", n), 32'(ras_count_o), 32'(v.eCnt));
        end
    endtask

    initial begin
        //            rst chk fv pc         instr  br jm tk mp exPc       exTgt      exIdx   eG   eP   eC    taken target     idx     ghr  ptr  cnt
        // Reset state and PHT/BTB training of the branch at 0x200 (GHR held at 0)
        tab.push_back('{0, 1, 1, 32'h100,  BEQ,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h104,  10'h040, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h200,  BEQ,   1, 0, 1, 0, 32'h200,   32'h180,   10'h080, 3'd0, 3'd0, 4'd0, 0, 32'h204,  10'h080, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h200,  BEQ,   1, 0, 1, 0, 32'h200,   32'h180,   10'h080, 3'd0, 3'd0, 4'd0, 1, 32'h180,  10'h080, 3'd0, 3'd0, 4'd0});
        // Counter at 11: a further taken must saturate, then one not-taken leaves 10
        tab.push_back('{0, 1, 0, 32'h200,  BEQ,   1, 0, 1, 0, 32'h200,   32'h180,   10'h080, 3'd0, 3'd0, 4'd0, 1, 32'h180,  10'h080, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h200,  BEQ,   1, 0, 0, 0, 32'h200,   32'h180,   10'h080, 3'd0, 3'd0, 4'd0, 1, 32'h180,  10'h080, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h200,  BEQ,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h180,  10'h080, 3'd0, 3'd0, 4'd0});
        // Speculative GHR shifts: taken -> 001, then index 0x081 (weak NT) -> 010
        tab.push_back('{0, 1, 1, 32'h200,  BEQ,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h180,  10'h080, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 1, 32'h200,  BEQ,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h204,  10'h081, 3'd1, 3'd0, 4'd0});
        // Call at 0x300, return at 0x400, then return on an empty stack
        tab.push_back('{0, 1, 1, 32'h300,  CALL,  0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h304,  10'h0C2, 3'd2, 3'd0, 4'd0});
        tab.push_back('{0, 1, 1, 32'h400,  RET,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h304,  10'h102, 3'd2, 3'd1, 4'd1});
        tab.push_back('{0, 1, 0, 32'h400,  RET,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h404,  10'h102, 3'd2, 3'd0, 4'd0});
        // Recovery: wrong-path call with non-branch mispredict, then branch mispredict
        tab.push_back('{0, 1, 1, 32'h1000, CALL,  0, 0, 0, 1, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h1004, 10'h002, 3'd2, 3'd1, 4'd0});
        tab.push_back('{0, 1, 1, 32'h200,  BEQ,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h180,  10'h080, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 1, 32'h1000, CALL,  1, 0, 0, 1, 32'h0,     32'h0,     10'h3FF, 3'd2, 3'd2, 4'd2, 0, 32'h1004, 10'h001, 3'd1, 3'd0, 4'd0});
        // Restored ptr=2 pops the untouched pushes from the call chain
        tab.push_back('{0, 1, 0, 32'h400,  RET,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h1014, 10'h104, 3'd4, 3'd2, 4'd2});
        tab.push_back('{0, 1, 1, 32'h400,  RET,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h1014, 10'h104, 3'd4, 3'd2, 4'd2});
        tab.push_back('{0, 1, 1, 32'h400,  RET,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h1084, 10'h104, 3'd4, 3'd1, 4'd1});
        // JAL at 0x500 trained to 0x800 replaces BTB entry 0 (0x200 then misses)
        tab.push_back('{0, 1, 0, 32'h500,  JMP,   0, 1, 0, 0, 32'h500,   32'h800,   10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h504,  10'h144, 3'd4, 3'd0, 4'd0});
        tab.push_back('{0, 1, 1, 32'h500,  JMP,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 1, 32'h800,  10'h144, 3'd4, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h200,  BEQ,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h204,  10'h084, 3'd4, 3'd0, 4'd0});
        // Reset with concurrent mispredict, call and BTB write: reset must win
        tab.push_back('{1, 0, 1, 32'h1000, CALL,  0, 1, 0, 1, 32'h200,   32'h900,   10'h0,   3'd7, 3'd3, 4'd3, 0, 32'h0,    10'h0,   3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h200,  JMP,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h204,  10'h080, 3'd0, 3'd0, 4'd0});
        tab.push_back('{0, 1, 0, 32'h500,  JMP,   0, 0, 0, 0, 32'h0,     32'h0,     10'h0,   3'd0, 3'd0, 4'd0, 0, 32'h504,  10'h140, 3'd0, 3'd0, 4'd0});

        reset = 1'b1;
        driveFetch(1'b0, 32'h0, 32'h13);
        clearEx();
        repeat (2) @(negedge clk);

        for (int i = 0; i <= 10; i++) applyVec(i);

        // Nine calls into an 8-deep stack: the ninth overwrites the oldest entry
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            clearEx();
            driveFetch(1'b1, 32'h1000 + 32'(16 * k), CALL);
            #1;
            checkVal($sformatf("call%0d taken", k), 32'(taken_o), 32'd0);
            checkVal($sformatf("call%0d target", k), target_o, 32'h1004 + 32'(16 * k));
            checkVal($sformatf("call%0d ras_count", k), 32'(ras_count_o), (k < 8) ? 32'(k) : 32'd8);
            checkVal($sformatf("call%0d ras_ptr", k), 32'(ras_ptr_o), 32'(k % 8));
        end
        // Eight returns see the last eight pushes newest first
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            driveFetch(1'b1, 32'h400, RET);
            #1;
            checkVal($sformatf("ret%0d taken", j), 32'(taken_o), 32'd1);
            checkVal($sformatf("ret%0d target", j), target_o, 32'h1004 + 32'(16 * (8 - j)));
            checkVal($sformatf("ret%0d ras_count", j), 32'(ras_count_o), 32'(8 - j));
            checkVal($sformatf("ret%0d ras_ptr", j), 32'(ras_ptr_o), 32'((9 - j) % 8));
        end
        // Ninth return underflows and falls through to a BTB miss
        @(negedge clk);
        driveFetch(1'b1, 32'h400, RET);
        #1;
        checkVal("ret_underflow taken", 32'(taken_o), 32'd0);
        checkVal("ret_underflow target", target_o, 32'h404);
        checkVal("ret_underflow ras_count", 32'(ras_count_o), 32'd0);

        for (int i = 11; i < tab.size(); i++) applyVec(i);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
